// File: rtl/cpu_pkg.sv
// Shared core definitions: load/store funct3 encodings, LSU states and
// request legality helpers.
package cpu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RDATA  = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } lsu_state_t;

    // Unsigned variants exist only for loads; anything else is not a load/store.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobes/replicated write data and
// load-data extraction with sign/zero extension.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we_mask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rd_shift_s;

    // Store strobes and lane replication by access size
    always_comb begin
        we_mask    = 4'b0000;
        wdata_lane = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                we_mask    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                we_mask    = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10: begin
                we_mask    = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                we_mask    = 4'b0000;
                wdata_lane = 32'h0000_0000;
            end
        endcase
    end

    assign rd_shift_s = rdata >> {addr_lo, 3'b000};

    // Load extraction and extension
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (funct3)
            F3_LB:   rdata_ext = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
            F3_LH:   rdata_ext = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
            F3_LW:   rdata_ext = rdata;
            F3_LBU:  rdata_ext = {24'h00_0000, rd_shift_s[7:0]};
            F3_LHU:  rdata_ext = {16'h0000, rd_shift_s[15:0]};
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the execute stage and the single-port synchronous
// data RAM; one outstanding request, registered response and RAM outputs.
module data_mem_lsu
    import cpu_pkg::*;
#(
    parameter int CPU_WIDTH = 32,
    parameter int RAM_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 s_reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [CPU_WIDTH-1:0] req_addr,
    input  logic [CPU_WIDTH-1:0] req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 resp_valid,
    output logic [CPU_WIDTH-1:0] resp_rdata,
    output logic [4:0]           resp_rd,
    output logic                 resp_misalign,
    output logic                 resp_fault,
    output logic                 mem_en,
    output logic [3:0]           mem_we,
    output logic [RAM_WIDTH-3:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_wait
);

    lsu_state_t state_r, state_nxt_s;

    logic                 xfer_s, fault_s, mis_s;
    logic                 we_r, fault_r, mis_r;
    logic [2:0]           f3_r;
    logic [1:0]           lo_r;
    logic [4:0]           rd_r;
    logic [CPU_WIDTH-1:0] load_data_r;

    logic [2:0]  al_f3_s;
    logic [1:0]  al_lo_s;
    logic [3:0]  al_we_s;
    logic [31:0] al_wdata_s, al_rdata_s;

    logic                 mem_en_nxt_s, resp_valid_nxt_s, resp_fault_nxt_s, resp_mis_nxt_s;
    logic [3:0]           mem_we_nxt_s;
    logic [RAM_WIDTH-3:0] mem_addr_nxt_s;
    logic [31:0]          mem_wdata_nxt_s;
    logic [CPU_WIDTH-1:0] resp_rdata_nxt_s;
    logic [4:0]           resp_rd_nxt_s;

    assign req_ready = (state_r == IDLE);
    assign xfer_s    = req_valid && (state_r == IDLE);
    assign fault_s   = (|req_addr[CPU_WIDTH-1:RAM_WIDTH]) || f3_illegal(req_we, req_funct3);
    assign mis_s     = f3_misaligned(req_funct3, req_addr[1:0]);

    // The shifter sees the live request while idle, the latched one afterwards.
    assign al_f3_s = (state_r == IDLE) ? req_funct3 : f3_r;
    assign al_lo_s = (state_r == IDLE) ? req_addr[1:0] : lo_r;

    lsu_align u_align (
        .funct3     (al_f3_s),
        .addr_lo    (al_lo_s),
        .wdata      (req_wdata[31:0]),
        .rdata      (mem_rdata),
        .we_mask    (al_we_s),
        .wdata_lane (al_wdata_s),
        .rdata_ext  (al_rdata_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = (fault_s || mis_s) ? ERR : ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_wait) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = we_r ? DONE : RDATA;
                end
            end
            RDATA:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output next values; RAM outputs are loaded on entry to ACCESS and frozen there
    always_comb begin
        mem_en_nxt_s = (state_nxt_s == ACCESS);
        if ((state_r == IDLE) && (state_nxt_s == ACCESS)) begin
            mem_we_nxt_s    = req_we ? al_we_s : 4'b0000;
            mem_addr_nxt_s  = req_addr[RAM_WIDTH-1:2];
            mem_wdata_nxt_s = req_we ? al_wdata_s : 32'h0000_0000;
        end else if (state_nxt_s == ACCESS) begin
            mem_we_nxt_s    = mem_we;
            mem_addr_nxt_s  = mem_addr;
            mem_wdata_nxt_s = mem_wdata;
        end else begin
            mem_we_nxt_s    = 4'b0000;
            mem_addr_nxt_s  = {(RAM_WIDTH-2){1'b0}};
            mem_wdata_nxt_s = 32'h0000_0000;
        end
        resp_valid_nxt_s = (state_r == DONE) || (state_r == ERR);
        resp_rdata_nxt_s = (state_r == DONE) ? load_data_r : {CPU_WIDTH{1'b0}};
        resp_rd_nxt_s    = resp_valid_nxt_s ? rd_r : 5'd0;
        resp_fault_nxt_s = (state_r == ERR) && fault_r;
        resp_mis_nxt_s   = (state_r == ERR) && mis_r;
    end

    // Registered response and RAM outputs
    always_ff @(posedge clk) begin
        if (s_reset) begin
            mem_en        <= 1'b0;
            mem_we        <= 4'b0000;
            mem_addr      <= {(RAM_WIDTH-2){1'b0}};
            mem_wdata     <= 32'h0000_0000;
            resp_valid    <= 1'b0;
            resp_rdata    <= {CPU_WIDTH{1'b0}};
            resp_rd       <= 5'd0;
            resp_fault    <= 1'b0;
            resp_misalign <= 1'b0;
        end else begin
            mem_en        <= mem_en_nxt_s;
            mem_we        <= mem_we_nxt_s;
            mem_addr      <= mem_addr_nxt_s;
            mem_wdata     <= mem_wdata_nxt_s;
            resp_valid    <= resp_valid_nxt_s;
            resp_rdata    <= resp_rdata_nxt_s;
            resp_rd       <= resp_rd_nxt_s;
            resp_fault    <= resp_fault_nxt_s;
            resp_misalign <= resp_mis_nxt_s;
        end
    end

    // Request latch and load-data capture
    always_ff @(posedge clk) begin
        if (s_reset) begin
            we_r        <= 1'b0;
            f3_r        <= 3'b000;
            lo_r        <= 2'b00;
            rd_r        <= 5'd0;
            fault_r     <= 1'b0;
            mis_r       <= 1'b0;
            load_data_r <= {CPU_WIDTH{1'b0}};
        end else if (xfer_s) begin
            we_r        <= req_we;
            f3_r        <= req_funct3;
            lo_r        <= req_addr[1:0];
            rd_r        <= req_rd;
            fault_r     <= fault_s;
            mis_r       <= mis_s && !fault_s;
            load_data_r <= {CPU_WIDTH{1'b0}};
        end else if (state_r == RDATA) begin
            load_data_r <= al_rdata_s;
        end else begin
            load_data_r <= load_data_r;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu with a behavioural RAM.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        s_reset, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_misalign, resp_fault;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_en, mem_wait;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:1023];
    logic [31:0] ram_q = 32'h0;

    int checks = 0;
    int failures = 0;

    int          r_lat, r_en;
    logic        r_stable, r_mis, r_flt;
    logic [3:0]  r_we;
    logic [9:0]  r_addr;
    logic [31:0] r_wd, r_rdata;
    logic [4:0]  r_rd;
    logic        seen_resp;

    always #5 clk = ~clk;

    data_mem_lsu #(.CPU_WIDTH(32), .RAM_WIDTH(12)) dut (
        .clk(clk), .s_reset(s_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_misalign(resp_misalign), .resp_fault(resp_fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    always @(posedge clk) begin
        if (mem_en && !mem_wait) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sample_mem();
        if (mem_en) begin
            if (r_en == 0) begin
                r_we = mem_we; r_addr = mem_addr; r_wd = mem_wdata;
            end else if (mem_we !== r_we || mem_addr !== r_addr || mem_wdata !== r_wd) begin
                r_stable = 1'b0;
            end
            r_en++;
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd, input int wait_n);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd; mem_wait = (wait_n > 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0;
        req_wdata = 32'h0; req_rd = 5'd0;
        r_lat = 0; r_en = 0; r_stable = 1'b1; r_we = 4'h0; r_addr = 10'h0; r_wd = 32'h0;
        sample_mem();
        while (!resp_valid && r_lat < 40) begin
            @(posedge clk); #1;
            r_lat++;
            sample_mem();
            if (r_lat == wait_n) mem_wait = 1'b0;
        end
        mem_wait = 1'b0;
        r_rdata = resp_rdata; r_rd = resp_rd; r_mis = resp_misalign; r_flt = resp_fault;
    endtask

    initial begin
        s_reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_flags", {30'h0, resp_fault, resp_misalign}, 32'h0);
        s_reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // SW then LW at 0x10
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3, 0);
        chk("sw_lat", r_lat, 32'd2);
        chk("sw_we", {28'h0, r_we}, 32'hF);
        chk("sw_addr", {22'h0, r_addr}, 32'h4);
        chk("sw_wdata", r_wd, 32'hDEADBEEF);
        chk("sw_rdata", r_rdata, 32'h0);
        chk("sw_rd", {27'h0, r_rd}, 32'd3);
        @(posedge clk); #1;
        chk("sw_pulse", {31'h0, resp_valid}, 32'h0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd7, 0);
        chk("lw_lat", r_lat, 32'd3);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_rd", {27'h0, r_rd}, 32'd7);
        chk("lw_we", {28'h0, r_we}, 32'h0);

        // Byte store and signed/unsigned byte loads
        run_req(1'b1, 3'b000, 32'h13, 32'h0000_0080, 5'd1, 0);
        chk("sb_we", {28'h0, r_we}, 32'h8);
        chk("sb_wdata", r_wd, 32'h80808080);
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd2, 0);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd2, 0);
        chk("lbu_rdata", r_rdata, 32'h00000080);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, 0);
        chk("lw_after_sb", r_rdata, 32'h80ADBEEF);

        // Half store to upper half and half loads
        run_req(1'b1, 3'b001, 32'h12, 32'h1234_BEEF, 5'd4, 0);
        chk("sh_we", {28'h0, r_we}, 32'hC);
        chk("sh_wdata", r_wd, 32'hBEEFBEEF);
        run_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd5, 0);
        chk("lh_rdata", r_rdata, 32'hFFFFBEEF);
        run_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd5, 0);
        chk("lhu_rdata", r_rdata, 32'h0000BEEF);
        run_req(1'b0, 3'b101, 32'h10, 32'h0, 5'd5, 0);
        chk("lhu_low", r_rdata, 32'h0000BEEF);

        // Misaligned half load
        run_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd9, 0);
        chk("mis_lat", r_lat, 32'd1);
        chk("mis_flags", {30'h0, r_flt, r_mis}, 32'h1);
        chk("mis_rdata", r_rdata, 32'h0);
        chk("mis_no_mem", r_en, 32'd0);
        chk("mis_rd", {27'h0, r_rd}, 32'd9);

        // Out-of-range, fault over misalign, illegal funct3
        run_req(1'b0, 3'b010, 32'h1000, 32'h0, 5'd6, 0);
        chk("oor_lat", r_lat, 32'd1);
        chk("oor_flags", {30'h0, r_flt, r_mis}, 32'h2);
        chk("oor_no_mem", r_en, 32'd0);
        run_req(1'b0, 3'b010, 32'h1001, 32'h0, 5'd6, 0);
        chk("prio_flags", {30'h0, r_flt, r_mis}, 32'h2);
        run_req(1'b1, 3'b100, 32'h20, 32'h55, 5'd6, 0);
        chk("ill_flags", {30'h0, r_flt, r_mis}, 32'h2);
        chk("ill_no_mem", r_en, 32'd0);
        run_req(1'b1, 3'b010, 32'h8000_0010, 32'h55, 5'd6, 0);
        chk("hi_addr_flags", {30'h0, r_flt, r_mis}, 32'h2);

        // Top RAM word is legal
        run_req(1'b1, 3'b010, 32'hFFC, 32'h12345678, 5'd8, 0);
        chk("top_sw_flags", {29'h0, r_flt, r_mis, resp_valid}, 32'h1);
        chk("top_sw_addr", {22'h0, r_addr}, 32'h3FF);
        run_req(1'b0, 3'b010, 32'hFFC, 32'h0, 5'd8, 0);
        chk("top_lw_rdata", r_rdata, 32'h12345678);

        // RAM stall for 5 cycles in ACCESS
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd10, 5);
        chk("wait_lat", r_lat, 32'd8);
        chk("wait_en_cycles", r_en, 32'd6);
        chk("wait_stable", {31'h0, r_stable}, 32'h1);
        chk("wait_addr", {22'h0, r_addr}, 32'h4);
        chk("wait_rdata", r_rdata, 32'hBEEFBEEF);

        // Reset in RDATA suppresses the response
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        s_reset = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b0;
        chk("mrst_ready", {31'h0, req_ready}, 32'h1);
        chk("mrst_resp", {31'h0, resp_valid}, 32'h0);
        chk("mrst_mem_en", {31'h0, mem_en}, 32'h0);
        seen_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("mrst_no_resp", {31'h0, seen_resp}, 32'h0);
        run_req(1'b0, 3'b010, 32'hFFC, 32'h0, 5'd12, 0);
        chk("mrst_lw_lat", r_lat, 32'd3);
        chk("mrst_lw_rdata", r_rdata, 32'h12345678);
        chk("mrst_lw_rd", {27'h0, r_rd}, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
